// File: rtl/theta_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : theta_pkg
//  Description : Shared tracker state encoding and small helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package theta_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        UNLOCKED = 2'd0,
        CAL      = 2'd1,
        LOCKED   = 2'd2
    } theta_state_e;

    // True once the first qualifying edge has been seen since the last loss of lock.
    function automatic logic is_tracking(input theta_state_e s);
        return (s != UNLOCKED);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Two-flop synchronizer followed by a registered rising-edge pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_edge (
    input  logic clk_in,
    input  logic rst_in,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/theta_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : theta_tracker
//  Description : Hall-index rotor angle tracker producing a slice index per revolution.
//  Revision    : 1.0  initial release
// ============================================================================
module theta_tracker
    import theta_pkg::*;
#(
    parameter int ROTATIONAL_RES = 256,
    parameter int PERIOD_WIDTH   = 32,
    parameter int MIN_PERIOD     = 4096,
    parameter int MAX_PERIOD     = 2**26
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              hall_in,
    output logic [$clog2(ROTATIONAL_RES)-1:0] dtheta,
    output logic                              dtheta_strobe,
    output logic                              locked,
    output logic [PERIOD_WIDTH-1:0]           period_out
);

    localparam int                       c_theta_w    = $clog2(ROTATIONAL_RES);
    localparam logic [PERIOD_WIDTH-1:0]  c_one        = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0]  c_min_period = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0]  c_max_period = PERIOD_WIDTH'(MAX_PERIOD);
    localparam logic [c_theta_w-1:0]     c_theta_last = c_theta_w'(ROTATIONAL_RES - 1);
    localparam logic [c_theta_w-1:0]     c_theta_one  = c_theta_w'(1);

    logic                    w_hall_edge;
    logic                    w_accept;
    logic                    w_timeout;
    logic                    w_slice_end;

    logic [PERIOD_WIDTH-1:0] period_cnt_q;
    logic [PERIOD_WIDTH-1:0] period_cnt_d;

    theta_state_e            state_q;
    logic                    locked_q;
    logic                    strobe_q;
    logic [c_theta_w-1:0]    dtheta_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [PERIOD_WIDTH-1:0] slice_len_q;
    logic [PERIOD_WIDTH-1:0] slice_cnt_q;

    sync_edge u_sync_edge (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .async_i (hall_in),
        .rise_o  (w_hall_edge)
    );

    // Edges closer than MIN_PERIOD are bounce and must not restart the counter.
    assign w_accept    = w_hall_edge && (period_cnt_q >= c_min_period);
    assign w_timeout   = (period_cnt_q >= c_max_period);
    assign w_slice_end = (slice_cnt_q == (slice_len_q - c_one));

    always_comb begin
        period_cnt_d = period_cnt_q;
        if (w_accept) begin
            period_cnt_d = c_one;
        end else if (period_cnt_q < c_max_period) begin
            period_cnt_d = period_cnt_q + c_one;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
        end
    end

    // The counter saturates at MAX_PERIOD, so any accepted edge is within range.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= UNLOCKED;
            locked_q    <= 1'b0;
            strobe_q    <= 1'b0;
            dtheta_q    <= '0;
            period_q    <= '0;
            slice_len_q <= '0;
            slice_cnt_q <= '0;
        end else begin
            strobe_q <= 1'b0;
            if (w_accept) begin
                if (!is_tracking(state_q)) begin
                    state_q <= CAL;
                end else begin
                    state_q     <= LOCKED;
                    locked_q    <= 1'b1;
                    period_q    <= period_cnt_q;
                    slice_len_q <= period_cnt_q >> c_theta_w;
                    slice_cnt_q <= '0;
                    dtheta_q    <= '0;
                    strobe_q    <= 1'b1;
                end
            end else if (w_timeout && is_tracking(state_q)) begin
                state_q     <= UNLOCKED;
                locked_q    <= 1'b0;
                dtheta_q    <= '0;
                slice_cnt_q <= '0;
            end else if (state_q == LOCKED) begin
                if (w_slice_end) begin
                    slice_cnt_q <= '0;
                    // Parking on the last slice keeps a slowing rotor from aliasing to 0.
                    if (dtheta_q != c_theta_last) begin
                        dtheta_q <= dtheta_q + c_theta_one;
                        strobe_q <= 1'b1;
                    end
                end else begin
                    slice_cnt_q <= slice_cnt_q + c_one;
                end
            end
        end
    end

    assign dtheta        = dtheta_q;
    assign dtheta_strobe = strobe_q;
    assign locked        = locked_q;
    assign period_out    = period_q;

endmodule
`default_nettype wire

// File: doc/theta_tracker.md
THETA_TRACKER -- requirements
Module: theta_tracker

Interface
REQ-001 SHALL have parameter ROTATIONAL_RES, default 256: angular slices per revolution, power of 2, at least 2.
REQ-002 SHALL have parameter PERIOD_WIDTH, default 32: width of the revolution-period counter.
REQ-003 SHALL have parameter MIN_PERIOD, default 4096: minimum accepted hall-edge spacing in cycles, at least ROTATIONAL_RES.
REQ-004 SHALL have parameter MAX_PERIOD, default 2**26: spacing above which the rotor is declared stalled; MIN_PERIOD < MAX_PERIOD < 2**PERIOD_WIDTH.
REQ-005 SHALL have port clk_in, input, 1 bit: system clock.
REQ-006 SHALL have port rst_in, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port hall_in, input, 1 bit: raw index sensor, asynchronous to clk_in, rising edge marks theta = 0.
REQ-008 SHALL have port dtheta, output, $clog2(ROTATIONAL_RES) bits: current angular slice, consumed by the column-selection stage.
REQ-009 SHALL have port dtheta_strobe, output, 1 bit: one-cycle pulse in the cycle dtheta takes a new value.
REQ-010 SHALL have port locked, output, 1 bit: dtheta is valid.
REQ-011 SHALL have port period_out, output, PERIOD_WIDTH bits: last accepted revolution period in cycles.

Function
REQ-012 SHALL pass hall_in through a 2-flop synchronizer, then a rising-edge detector; hall_edge is one cycle wide.
REQ-013 SHALL run a free period counter that increments every cycle, saturates at MAX_PERIOD, and returns to 1 in the cycle after an accepted edge.
REQ-014 SHALL accept a hall_edge only when period counter >= MIN_PERIOD; all other edges are ignored (debounce) and do not restart the counter.
REQ-015 SHALL implement three states: UNLOCKED, CAL, LOCKED.
REQ-016 UNLOCKED: on an accepted edge, go to CAL; the period is discarded.
REQ-017 CAL: on an accepted edge with counter <= MAX_PERIOD, latch period_out and go to LOCKED.
REQ-018 LOCKED: each accepted edge relatches period_out and stays in LOCKED.
REQ-019 In CAL or LOCKED, if the counter reaches MAX_PERIOD without an accepted edge, SHALL go to UNLOCKED.
REQ-020 slice_len SHALL equal the accepted period shifted right by log2(ROTATIONAL_RES); no divider. It SHALL be nonzero by REQ-003.
REQ-021 Cycle after an accepted edge that enters or stays in LOCKED: dtheta = 0, slice counter = 0, dtheta_strobe = 1.
REQ-022 In LOCKED, the slice counter SHALL increment every cycle.
REQ-023 When the slice counter reaches slice_len-1 it SHALL clear, and dtheta SHALL increment with dtheta_strobe = 1, unless dtheta = ROTATIONAL_RES-1.
REQ-024 At ROTATIONAL_RES-1, dtheta SHALL hold with no strobe (no wrap until the next edge, so a slowing rotor never aliases to slice 0).
REQ-025 If an accepted edge coincides with a slice boundary, the edge SHALL win: dtheta = 0.
REQ-026 locked SHALL be 1 only in LOCKED.
REQ-027 Outside LOCKED: dtheta = 0 and dtheta_strobe = 0.
REQ-028 period_out SHALL hold its value through UNLOCKED.
REQ-029 Latency: hall_in rising, stable, to dtheta_strobe SHALL be 4 cycles (2 sync, 1 edge, 1 register).

Reset
REQ-030 rst_in asserted SHALL immediately force: state UNLOCKED, dtheta 0, dtheta_strobe 0, locked 0, period_out 0, all counters 0, synchronizer flops 0.
REQ-031 Reset mid-revolution SHALL require two accepted edges after release before locked rises.

Structure
REQ-032 Package theta_pkg SHALL hold the state enum (UNLOCKED, CAL, LOCKED).
REQ-033 Sub-module sync_edge SHALL implement the 2-flop synchronizer and rising-edge pulse, with the same clk_in/rst_in.
REQ-034 All other logic SHALL be in theta_tracker.

Verification (ROTATIONAL_RES=8, MIN_PERIOD=16, MAX_PERIOD=1000)
REQ-035 Hall edges every 80 cycles: locked rises after 2nd edge; period_out = 80; dtheta steps 0..7, one strobe every 10 cycles, 8 strobes per revolution.
REQ-036 Glitch edge 5 cycles after an accepted edge: ignored; period_out and dtheta sequence unchanged.
REQ-037 Period stretches 80 -> 120: dtheta reaches 7 at cycle 70, holds 50 cycles with no strobe, returns to 0 on the edge; period_out = 120.
REQ-038 Edges stop: at 1000 cycles after last edge, locked = 0 and dtheta = 0; two new edges 80 cycles apart relock.
REQ-039 rst_in pulsed while LOCKED at dtheta = 4: same cycle, all outputs reset; next edge does not set locked, the following edge does.
REQ-040 Edge on same cycle as 10-cycle slice boundary: dtheta = 0 and one strobe, not an increment.
